// File: rtl/pc_ctrl_if.sv
// Fetch-sequencer bus: redirect/exception inputs, instruction-memory handshake
// and the fetched-instruction buffer outputs of pc_ctrl.
interface pc_ctrl_if;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        exc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc;
   logic [31:0] epc;
   logic        misalign;

   modport master (
      input  stall, redirect, redirect_pc, exc, imem_ack, imem_rdata,
      output imem_req, imem_addr, instr_valid, instr, instr_pc, pc, epc, misalign
   );

   modport slave (
      output stall, redirect, redirect_pc, exc, imem_ack, imem_rdata,
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc, epc, misalign
   );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch sequencer: owns the PC, drives the imem handshake, buffers one instruction.
// Optional PC_ALIGN_CHECK_EN turns misaligned redirects into exceptions.
module pc_ctrl #(
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter logic [31:0] EXC_VEC   = 32'h0000_0080
) (
   input  logic       clk,
   input  logic       rst_n,
   pc_ctrl_if.master  bus
);
   typedef enum logic [1:0] {BOOT, FETCH, FULL} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic        r_instr_valid;
   logic [31:0] r_epc;
   logic        r_pend;
   logic        r_pend_exc;
   logic [31:0] r_pend_pc;
   logic        r_imem_req;
   logic        r_misalign;

   logic        w_redir_bad;
   logic [31:0] w_redir_tgt;
   logic        w_exc_evt;
   logic        w_evt;
   logic [31:0] w_tgt;

`ifdef PC_ALIGN_CHECK_EN
   assign w_redir_bad = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
   assign w_redir_tgt = bus.redirect_pc;
`else
   assign w_redir_bad = 1'b0;
   assign w_redir_tgt = {bus.redirect_pc[31:2], 2'b00};
`endif

   assign w_exc_evt = bus.exc | w_redir_bad;
   assign w_evt     = bus.exc | bus.redirect;
   // A pending exception is never displaced by a later redirect
   assign w_tgt     = (w_exc_evt || (r_pend && r_pend_exc)) ? EXC_VEC : w_redir_tgt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= BOOT;
         r_pc          <= RESET_VEC;
         r_instr       <= 32'h0;
         r_instr_pc    <= 32'h0;
         r_instr_valid <= 1'b0;
         r_epc         <= 32'h0;
         r_pend        <= 1'b0;
         r_pend_exc    <= 1'b0;
         r_pend_pc     <= 32'h0;
         r_imem_req    <= 1'b0;
         r_misalign    <= 1'b0;
      end else begin
         r_misalign <= 1'b0;
         case (r_state)
            BOOT: begin
               r_state    <= FETCH;
               r_imem_req <= 1'b1;
            end
            FETCH: begin
               r_misalign <= w_redir_bad;
               if (w_exc_evt)
                  r_epc <= r_pc;
               if (!bus.imem_ack) begin
                  if (w_evt) begin
                     r_pend     <= 1'b1;
                     r_pend_exc <= r_pend_exc | w_exc_evt;
                     r_pend_pc  <= w_tgt;
                  end
               end else if (w_evt) begin
                  r_pc       <= w_tgt;
                  r_pend     <= 1'b0;
                  r_pend_exc <= 1'b0;
               end else if (r_pend) begin
                  r_pc       <= r_pend_pc;
                  r_pend     <= 1'b0;
                  r_pend_exc <= 1'b0;
               end else begin
                  r_instr       <= bus.imem_rdata;
                  r_instr_pc    <= r_pc;
                  r_instr_valid <= 1'b1;
                  r_pc          <= r_pc + 32'd4;
                  r_imem_req    <= 1'b0;
                  r_state       <= FULL;
               end
            end
            FULL: begin
               r_misalign <= w_redir_bad;
               if (w_evt || !bus.stall) begin
                  if (w_exc_evt)
                     r_epc <= r_instr_pc;
                  if (w_evt)
                     r_pc <= w_tgt;
                  r_instr_valid <= 1'b0;
                  r_imem_req    <= 1'b1;
                  r_state       <= FETCH;
               end
            end
            default: begin
               r_state    <= BOOT;
               r_imem_req <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_req    = r_imem_req;
   assign bus.imem_addr   = r_pc;
   assign bus.pc          = r_pc;
   assign bus.instr       = r_instr;
   assign bus.instr_pc    = r_instr_pc;
   assign bus.instr_valid = r_instr_valid;
   assign bus.epc         = r_epc;
   assign bus.misalign    = r_misalign;
endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch sequencer that owns the program counter register and drives the instruction-memory request handshake. It sits between the `pc` register stage and the decode stage of the processor datapath. Each cycle it selects the next PC: reset vector, exception vector, branch/jump redirect, or sequential +4. It holds the fetched instruction in a one-entry buffer until decode consumes it, and squashes in-flight fetches on redirect.

## Interface
- `RESET_VEC`, 32'h0000_0000, PC loaded on reset
- `EXC_VEC`, 32'h0000_0080, PC loaded on exception
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `stall`  in  1  decode not accepting; buffered instruction is held
- `redirect`  in  1  taken branch/jump
- `redirect_pc`  in  32  redirect target
- `exc`  in  1  exception request; overrides `redirect`
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, equal to `pc`
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle
- `imem_rdata`  in  32  fetched word
- `instr_valid`  out  1  buffer holds a valid instruction
- `instr`  out  32  buffered instruction
- `instr_pc`  out  32  address of `instr`
- `pc`  out  32  current fetch PC
- `epc`  out  32  PC saved on the last exception
- `misalign`  out  1  misaligned redirect flag (see Configuration)

## Operation
- States: BOOT, FETCH, FULL. Registers: `pc`, `instr`, `instr_pc`, `instr_valid`, `epc`, `pend` (1 bit), `pend_pc` (32 bits).
- BOOT:
  - `imem_req`=0.
  - Always goes to FETCH on the next cycle.
  - `redirect`/`exc` are ignored.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`.
  - `imem_addr` must stay stable while `imem_req` is high and `imem_ack` is low.
  - `exc` or `redirect` without `imem_ack`: set `pend`=1 and `pend_pc`=target (`exc` → `EXC_VEC`). A later event overwrites the target; `exc` is never overwritten by `redirect`.
  - `imem_ack` with `pend`=0 and no `exc`/`redirect`:
    - `instr`=`imem_rdata`, `instr_pc`=`pc`, `instr_valid`=1.
    - `pc`=`pc`+4.
    - Go to FULL.
  - `imem_ack` with `pend`=1, or with `exc`/`redirect` in the same cycle:
    - Discard the data.
    - `pc`=target (same-cycle event wins over `pend_pc`), `pend`=0.
    - Stay in FETCH; the new request goes out next cycle.
- FULL:
  - `imem_req`=0 and `instr_valid`=1.
  - `exc`: `epc`=`instr_pc`, `pc`=`EXC_VEC`, `instr_valid`=0, go to FETCH.
  - Else `redirect`: `pc`=`redirect_pc`, `instr_valid`=0, go to FETCH.
  - Else `stall`=0: instruction consumed, `instr_valid`=0, go to FETCH.
  - Else (`stall`=1): hold all state.
- An exception taken in FETCH sets `epc`=`pc` (the in-flight address).
- Arithmetic: `pc`+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000.

## Timing
- Reset (asynchronous, any time, including mid-handshake) forces:
  - state=BOOT, `pc`=`RESET_VEC`
  - `imem_req`=0, `instr_valid`=0, `misalign`=0, `pend`=0
  - `instr`=0, `instr_pc`=0, `epc`=0
- The first request is at cycle 2 after reset release (cycle 1 is BOOT).
- A zero-wait fetch (ack in the same cycle as req) shows `instr_valid` in the following cycle.
- Unstalled throughput: one instruction every 2 cycles (FETCH, FULL).
- Redirect or exc in FULL: the new `imem_addr` appears in the next cycle.
- Redirect during an outstanding fetch: the new address appears in the cycle after `imem_ack`.
- `imem_ack` outside FETCH is ignored.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - A `redirect` with `redirect_pc[1:0]`≠0 is treated as an exception: `pc`=`EXC_VEC`, `epc` follows the same rules as `exc`.
  - `misalign`=1 for exactly one cycle.
- `PC_ALIGN_CHECK_EN` not defined:
  - `redirect_pc[1:0]` is forced to 0 on load.
  - `misalign` is tied to 0.

## Test plan
- Reset release with `imem_ack` held at 1 and rdata=32'h2008_0001 → BOOT, then req at addr 0, then `instr_valid`=1 with `instr`=32'h2008_0001 and `instr_pc`=0, then next req at addr 4.
- `stall`=1 for 3 cycles in FULL → `instr`/`instr_pc` held, `imem_req`=0; after release, next req at `instr_pc`+4.
- `redirect` to 32'h0000_0100 while a req at 32'h10 waits 2 cycles for ack → data discarded, `instr_valid` stays 0, next req at 32'h100.
- `exc` and `redirect` in the same FULL cycle with `instr_pc`=32'h40 → `pc`=32'h80, `epc`=32'h40.
- `pc`=32'hFFFF_FFFC fetch acked → `pc` wraps to 0.
- Redirect to 32'h0000_0102: with `PC_ALIGN_CHECK_EN` → `misalign` pulse and `pc`=32'h80; without it → `pc`=32'h100.
